// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front-panel blocks.
// Holds the result-pager state encoding, the LED byte width and the
// default result word width.
package cpu_pkg;

  localparam int LED_W     = 8;
  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

endpackage

// File: rtl/btn_edge_det.sv
// Push-button rising-edge detector.
// Two-flop synchronizer plus a previous-value flop. The output is high for
// exactly one clk cycle per rising edge of the synchronized level.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   i_level raw, asynchronous button level
//   o_edge  one-cycle pulse per press
module btn_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Synchronize the raw level and keep its previous synchronized value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_level;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_edge = r_sync2 & ~r_prev;

endmodule

// File: rtl/result_pager.sv
// Result pager: deserializes the LSB-first result stream from the CPU core
// into a holding register and shows it on the LEDs one byte (page) at a time.
// A button press advances the page; wrapping past the last page marks the
// word as read. A word in progress does not disturb the displayed word.
// Optional feature (macro RESULT_PAGER_AUTO_PAGE_EN): a free-running
// AUTO_DIV-bit counter also advances the page in SHOW each time it wraps.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_ser_bit         serial result bit, LSB first
//   i_ser_valid       i_ser_bit valid this cycle
//   i_ser_last        final bit of a word (with i_ser_valid)
//   i_btn_level       raw push-button level
//   o_led_out         displayed byte of the held word
//   o_page            index of the displayed byte
//   o_result_ready    held word has unread data
//   o_busy            capture in progress
//   o_overrun         sticky: word completed while previous one was unread
module result_pager
  import cpu_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int AUTO_DIV = 22,
  localparam int PAGES    = WIDTH / LED_W,
  localparam int PW       = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ser_bit,
  input  logic             i_ser_valid,
  input  logic             i_ser_last,
  input  logic             i_btn_level,
  output logic [LED_W-1:0] o_led_out,
  output logic [PW-1:0]    o_page,
  output logic             o_result_ready,
  output logic             o_busy,
  output logic             o_overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             r_state,  w_nx_state;
  logic [WIDTH-1:0]   r_shift,  w_nx_shift;
  logic [WIDTH-1:0]   r_hold,   w_nx_hold;
  logic [CW-1:0]      r_bitcnt, w_nx_bitcnt;
  logic [PW-1:0]      r_page,   w_nx_page;
  logic               r_ready,  w_nx_ready;
  logic               r_overrun, w_nx_overrun;
  logic               r_held,   w_nx_held;

  logic               w_btn_edge;
  logic               w_tick;
  logic               w_start;
  logic               w_complete;
  logic               w_adv;
  logic [WIDTH-1:0]   w_base;
  logic [CW-1:0]      w_pos;
  logic [WIDTH-1:0]   w_word;
  logic [WIDTH-1:0]   w_led_shift;

  btn_edge_det u_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_level (i_btn_level),
    .o_edge  (w_btn_edge)
  );

`ifdef RESULT_PAGER_AUTO_PAGE_EN
  logic [AUTO_DIV-1:0] r_auto_cnt;

  // Free-running auto-page divider, restarted on each completed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_auto_cnt <= '0;
    end else if (w_complete) begin
      r_auto_cnt <= '0;
    end else begin
      r_auto_cnt <= r_auto_cnt + {{(AUTO_DIV-1){1'b0}}, 1'b1};
    end
  end

  // Tick on the cycle the counter is about to wrap.
  assign w_tick = &r_auto_cnt;
`else
  // Auto-paging compiled out: the tick can never fire.
  assign w_tick = (AUTO_DIV < 0);
`endif

  // Next-state, capture and paging logic.
  always_comb begin
    w_nx_state   = r_state;
    w_nx_shift   = r_shift;
    w_nx_hold    = r_hold;
    w_nx_bitcnt  = r_bitcnt;
    w_nx_page    = r_page;
    w_nx_ready   = r_ready;
    w_nx_overrun = r_overrun;
    w_nx_held    = r_held;

    w_start    = i_ser_valid & (r_state != ST_SHIFT);
    w_complete = i_ser_valid & i_ser_last;

    // A new capture starts from an empty shift register at bit 0.
    if (w_start) begin
      w_base = '0;
      w_pos  = '0;
    end else begin
      w_base = r_shift;
      w_pos  = r_bitcnt;
    end
    // A shift by WIDTH or more drops the bit, which discards overflow bits.
    w_word = w_base | (WIDTH'(i_ser_bit) << w_pos);

    w_adv = (w_btn_edge & r_held & (r_state != ST_IDLE)) |
            (w_tick & (r_state == ST_SHOW));

    if (w_complete) begin
      // Completion wins over a simultaneous page advance.
      w_nx_hold    = w_word;
      w_nx_shift   = '0;
      w_nx_bitcnt  = '0;
      w_nx_page    = '0;
      w_nx_ready   = 1'b1;
      w_nx_overrun = r_overrun | r_ready;
      w_nx_held    = 1'b1;
      w_nx_state   = ST_SHOW;
    end else begin
      if (i_ser_valid) begin
        w_nx_shift = w_word;
        w_nx_state = ST_SHIFT;
        if (w_pos != CW'(WIDTH)) begin
          w_nx_bitcnt = w_pos + CW'(1);
        end else begin
          w_nx_bitcnt = w_pos;
        end
      end else begin
        w_nx_state = r_state;
      end

      if (w_adv) begin
        if (r_page == PW'(PAGES - 1)) begin
          w_nx_page  = '0;
          w_nx_ready = 1'b0;
        end else begin
          w_nx_page  = r_page + PW'(1);
        end
      end else begin
        w_nx_page = r_page;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_hold    <= '0;
      r_bitcnt  <= '0;
      r_page    <= '0;
      r_ready   <= 1'b0;
      r_overrun <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_nx_state;
      r_shift   <= w_nx_shift;
      r_hold    <= w_nx_hold;
      r_bitcnt  <= w_nx_bitcnt;
      r_page    <= w_nx_page;
      r_ready   <= w_nx_ready;
      r_overrun <= w_nx_overrun;
      r_held    <= w_nx_held;
    end
  end

  // Page select as a shift by page*8.
  assign w_led_shift    = r_hold >> {r_page, 3'b000};
  assign o_led_out      = w_led_shift[LED_W-1:0];
  assign o_page         = r_page;
  assign o_result_ready = r_ready;
  assign o_busy         = (r_state == ST_SHIFT);
  assign o_overrun      = r_overrun;

endmodule
